// File: rtl/amadeus_mem_arbiter.sv
// Round-robin arbiter of NUM_CH streaming clients onto one memory port, one beat in flight.
// Optional AMADEUS_MEM_ARB_ERR_EN: sticky error on stray mem_valid or pointer wrap.
`ifndef MEM_BANDWIDTH
`define MEM_BANDWIDTH 4
`endif
`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 16
`endif

module amadeus_mem_arbiter #(
  parameter int                NUM_CH    = 4,
  parameter int                DATA_W    = `MEM_BANDWIDTH*8,
  parameter int                ADDR_W    = `MEM_ADDR_SIZE,
  parameter logic [NUM_CH-1:0] WR_MASK   = NUM_CH'(4'b1000),
  parameter int                ADDR_STEP = `MEM_BANDWIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NUM_CH*ADDR_W-1:0] base_addr,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_ack,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]        ch_rdata_valid,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_write_data,
  output logic                     mem_read,
  output logic                     mem_write,
  input  logic                     mem_valid,
  input  logic [DATA_W-1:0]        mem_read_data,
  output logic                     busy,
  output logic                     error
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   grant_reg, last_grant_reg, pick;
  logic               found, grant_now, complete, skip_inc_reg;
  logic [ADDR_W-1:0]  ptr_reg  [NUM_CH];
  logic [ADDR_W-1:0]  base_arr [NUM_CH];
  logic [DATA_W-1:0]  wdata_arr[NUM_CH];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign base_arr[gi]  = base_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = ch_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // First requester searching upward from the channel after the last grant.
  always_comb begin
    int c;
    found = 1'b0;
    pick  = '0;
    c     = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      c = (int'(last_grant_reg) + i) % NUM_CH;
      if (!found && ch_req[c]) begin
        found = 1'b1;
        pick  = IDX_W'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    grant_now  = 1'b0;
    complete   = 1'b0;
    case (state_reg)
      IDLE: if (found) begin
        grant_now  = 1'b1;
        state_next = ISSUE;
      end
      ISSUE: if (mem_valid) begin
        complete   = 1'b1;
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_reg      <= '0;
      last_grant_reg <= IDX_W'(NUM_CH-1);
      skip_inc_reg   <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      ch_rdata       <= '0;
      ch_ack         <= '0;
      ch_rdata_valid <= '0;
      for (int i = 0; i < NUM_CH; i++) ptr_reg[i] <= '0;
    end else begin
      ch_ack         <= '0;
      ch_rdata_valid <= '0;
      if (grant_now) begin
        grant_reg      <= pick;
        mem_addr       <= ptr_reg[pick];
        mem_write_data <= wdata_arr[pick];
        mem_read       <= !WR_MASK[pick];
        mem_write      <= WR_MASK[pick];
        skip_inc_reg   <= start;
      end
      if (complete) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        ch_ack    <= NUM_CH'(1) << grant_reg;
        if (!WR_MASK[grant_reg]) begin
          ch_rdata       <= mem_read_data;
          ch_rdata_valid <= NUM_CH'(1) << grant_reg;
        end
        // A beat that straddles a start belongs to the previous layer: no pointer or priority update.
        if (!(skip_inc_reg || start)) last_grant_reg <= grant_reg;
      end
      if (start) begin
        last_grant_reg <= IDX_W'(NUM_CH-1);
        if (state_reg == ISSUE) skip_inc_reg <= 1'b1;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (start)
          ptr_reg[i] <= base_arr[i];
        else if (complete && !skip_inc_reg && grant_reg == IDX_W'(i))
          ptr_reg[i] <= ptr_reg[i] + STEP;
      end
    end
  end

`ifdef AMADEUS_MEM_ARB_ERR_EN
  logic              err_reg;
  logic              stray, wrap;
  logic [ADDR_W-1:0] ptr_sel;

  assign ptr_sel = ptr_reg[grant_reg];
  assign stray   = mem_valid && (state_reg != ISSUE);
  // ptr + STEP overflows exactly when ptr > (2^ADDR_W - 1 - STEP) == ~STEP.
  assign wrap    = complete && !(skip_inc_reg || start) && (ptr_sel > ~STEP);

  always_ff @(posedge clk) begin
    if (!rst_n)              err_reg <= 1'b0;
    else if (stray || wrap)  err_reg <= 1'b1;
    else if (start)          err_reg <= 1'b0;
  end
  assign error = err_reg;
`else
  assign error = 1'b0;
`endif

endmodule

// File: doc/amadeus_mem_arbiter.md
# amadeus_mem_arbiter

Parametrised memory-port arbiter sitting between the accelerator's streaming clients (decompressor read ports, compressor write ports, and future weight/psum spill ports) and the single external memory port at the top level. It owns one auto-incrementing address pointer per channel, loaded from per-layer base addresses at layer start. It arbitrates channel requests round-robin and runs a level handshake against memory with one transaction in flight. Read data returns to the requesting channel with a one-hot valid.

## Interface
- NUM_CH, 4, number of client channels (2..8)
- DATA_W, `MEM_BANDWIDTH*8, memory beat width in bits
- ADDR_W, `MEM_ADDR_SIZE, memory address width
- WR_MASK, 4'b1000, NUM_CH bits; bit i=1 makes channel i a write channel, 0 a read channel
- ADDR_STEP, `MEM_BANDWIDTH, pointer increment per completed beat
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  one-cycle pulse; loads all pointers from base_addr
- base_addr  in  NUM_CH×ADDR_W  per-channel start address; sampled only on start
- ch_req  in  NUM_CH  per-channel request level
- ch_wdata  in  NUM_CH×DATA_W  write data (write channels only)
- ch_ack  out  NUM_CH  one-cycle pulse; the channel's beat is complete
- ch_rdata  out  DATA_W  registered read data
- ch_rdata_valid  out  NUM_CH  one-hot pulse, coincident with ch_ack, read channels only
- mem_addr  out  ADDR_W  transaction address
- mem_write_data  out  DATA_W  write beat
- mem_read  out  1  read request level
- mem_write  out  1  write request level
- mem_valid  in  1  memory completion strobe
- mem_read_data  in  DATA_W  read beat, valid with mem_valid
- busy  out  1  transaction in flight
- error  out  1  protocol error flag (see Configuration)

## Operation
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - If any ch_req bit is high, grant the first requesting channel searching from (last_grant+1) mod NUM_CH.
  - Latch the grant index, the channel pointer into mem_addr, and ch_wdata into mem_write_data.
  - Assert mem_read or mem_write per WR_MASK, then move to ISSUE.
- ISSUE:
  - Hold mem_addr, mem_write_data and mem_read/mem_write stable until mem_valid is sampled high.
  - On that edge: deassert the request, capture mem_read_data into ch_rdata (read channels), increment the granted pointer by ADDR_STEP modulo 2^ADDR_W, and update last_grant. Move to DONE.
- DONE: pulse ch_ack[grant]; also pulse ch_rdata_valid[grant] for a read channel. Return to IDLE.
- Requester rules:
  - Hold ch_req and ch_wdata stable until ch_ack.
  - Dropping ch_req before the grant withdraws the request.
  - Dropping ch_req after the grant is ignored; the beat still completes.
- start:
  - Reloads every pointer from base_addr and resets last_grant to NUM_CH-1, so channel 0 has first priority.
  - If a transaction is in flight, it finishes at its latched address and is acked normally. Its completion does not increment the freshly loaded pointer.
- start coincident with an IDLE grant: the grant uses the old pointer, and the new pointers apply from the next grant.
- ch_rdata holds its last value between reads.

## Timing
- Reset (rst_n low at an edge) forces the following, regardless of state:
  - FSM to IDLE
  - mem_read, mem_write, busy, ch_ack, ch_rdata_valid, error to 0
  - mem_addr, mem_write_data, ch_rdata, all pointers to 0
  - last_grant to NUM_CH-1
- Request sampled in IDLE at edge t → mem_read/mem_write high from t+1.
- mem_valid sampled at edge t+k (k≥1) → request low from t+k+1, ch_ack from t+k+1 for one cycle.
- Throughput: one beat per k+2 cycles. Minimum: 3 cycles per beat with same-cycle mem_valid.
- busy is high in ISSUE and DONE.
- mem_valid in ISSUE with no request asserted cannot occur by construction. mem_valid in IDLE or DONE is a protocol error.

## Configuration
- AMADEUS_MEM_ARB_ERR_EN defined:
  - error goes high the cycle after mem_valid is sampled in IDLE or DONE, or when any pointer increment wraps past 2^ADDR_W.
  - error is sticky until start or reset.
  - The stray mem_valid is otherwise ignored.
- Undefined: error is tied 0; stray mem_valid is silently ignored; wrap is silent.

## Test plan
- Reset, then base_addr[0]=0x100 and start; read on ch0 with mem_valid 2 cycles after mem_read. Expect mem_addr=0x100, ch_ack[0] and ch_rdata_valid[0] with ch_rdata=mem_read_data, and the next ch0 read at 0x100+ADDR_STEP.
- All 4 channels request continuously (ch3 is a write). Expect grant order 0,1,2,3,0; ch3 drives mem_write with mem_write_data=ch_wdata[3] and gets ch_ack[3] with no ch_rdata_valid.
- Pulse start mid-ISSUE with new bases. Expect the in-flight beat at the old address to ack, then the next grant to use the new base unincremented.
- Pointer at 2^ADDR_W-ADDR_STEP completes. Expect wrap to 0; with AMADEUS_MEM_ARB_ERR_EN, error=1 until start.
- Stray mem_valid in IDLE. Expect no ch_ack; error=1 only with the macro defined.
- rst_n low during ISSUE. Expect mem_read=0 and busy=0 on the next edge, and no ch_ack afterwards.
